temp_disp_scan: RTL and testbench
=================================

Name: temp_disp_scan

Overview:
- Downstream display stage for the temperature converter.
- Captures the converter's 4-bit result, unit select and over-temperature flag on an update strobe.
- Splits the result into decimal digits and drives a 4-digit multiplexed common-anode seven-segment display.
- Blinks the whole display while the over-temperature flag is held.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2 or more.
- BLINK_DIV, 250: scan ticks per blink half-period in ALARM; legal range 1 or more.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- clr  in  1  reset, asynchronous, active-low; one clock domain.
- temp  in  4  converted temperature, unsigned 0..15.
- unit  in  2  unit select: 00 = C, 01 = F, 10 = K, 11 = invalid.
- over  in  1  over-temperature flag (comparator gt).
- upd  in  1  capture strobe; sampled at each clk edge.
- seg  out  7  segments, active-low, bit order gfedcba (seg[0] = a).
- dp  out  1  decimal point, active-low.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.

Behaviour:
- Reset (clr = 0, asynchronous), all registers and outputs:
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - state = BLANK, scan_cnt = 0, idx = 0, blink_cnt = 0, phase = 1.
  - Hold registers cleared to 0.
- Reset release: operation starts on the first clk edge with clr = 1.
- Capture: when upd = 1 at an edge, temp, unit and over are loaded into hold registers h_temp, h_unit and h_over.
- State machine, evaluated on the edge after a capture:
  - BLANK -> SHOW if h_over = 0; BLANK -> ALARM if h_over = 1.
  - SHOW -> ALARM when a capture sets h_over = 1.
  - ALARM -> SHOW when a capture clears h_over.
  - No capture means no state change. In BLANK, an stays at 4'b1111.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = 1 for exactly one cycle when scan_cnt = SCAN_DIV-1.
  - On tick, idx advances 0 -> 1 -> 2 -> 3 -> 0.
  - The counter runs in every state.
- Digit decode:
  - tens = 1 if h_temp >= 10, else 0; ones = h_temp - 10*tens.
  - idx 0: unit glyph. C = 7'b1000110, F = 7'b0001110, K = 7'b0001001, invalid = E = 7'b0000110.
  - idx 1: ones digit, standard glyph (0 = 7'b1000000, 1 = 7'b1111001, 5 = 7'b0010010, 8 = 7'b0000000).
  - idx 2: tens digit; blank (7'b1111111) when tens = 0, giving leading-zero suppression.
  - idx 3: always blank.
- dp: low only on idx 0 while in ALARM, otherwise high.
- Output timing:
  - an, seg and dp are registered: one cycle latency from idx/hold change to the pins.
  - an is one-hot low at bit idx.
  - Segments change in the same cycle as an; no blanking gap is required.
- Blink (ALARM only):
  - blink_cnt counts ticks 0..BLINK_DIV-1; on wrap, phase toggles.
  - phase = 0 forces an = 4'b1111.
  - Entering ALARM clears blink_cnt and sets phase = 1.
  - In SHOW, phase is held at 1.
- Simultaneous events:
  - upd together with tick: both take effect in the same edge; the new value appears on the next registered output.
  - upd held high: re-captures every cycle; the last sample wins.
- Reset mid-operation: everything returns to reset values immediately, regardless of clk.
- Width rules: scan_cnt width is $clog2(SCAN_DIV); blink_cnt width is $clog2(BLINK_DIV+1); no overflow beyond terminal count.

Decomposition:
- Package temp_disp_pkg holds:
  - Unit code constants UNIT_C, UNIT_F, UNIT_K.
  - Glyph constants for 0-9, C, F, K, E and BLANK.
  - State enum: BLANK, SHOW, ALARM.
- Sub-module seg7_encode: combinational 4-bit symbol code to 7-bit active-low segments. Used once in the output path.

Test Plan:
- Reset and no upd -> an = 1111, seg = 1111111, dp = 1 held for 3*SCAN_DIV cycles.
- SCAN_DIV = 4, upd with temp = 13, unit = 00, over = 0 -> SHOW. Scan cycles an 1110 / 1101 / 1011 / 0111 every 4 clks, with seg C (1000110), 3 (0110000), 1 (1111001), blank (1111111); dp = 1 throughout.
- temp = 5, unit = 10 -> idx 2 blank (leading zero suppressed), idx 1 = 0010010, idx 0 = K (0001001).
- unit = 11 -> idx 0 = E (0000110).
- over = 1, BLINK_DIV = 2 -> ALARM. an active for 2 ticks, 1111 for 2 ticks, repeating; dp low on idx 0 when lit. Then upd with over = 0 -> SHOW, no further blanking.
- clr driven low mid-scan between clk edges -> outputs reach reset values before the next edge. After release, upd is required before any digit lights.

Source files
------------

// File: rtl/temp_disp_pkg.sv
// Shared constants for the temperature display: unit codes, seven-segment glyphs,
// internal symbol codes fed to the segment encoder, and the display state enum.
`timescale 1ns/1ps
package temp_disp_pkg;

    localparam logic [1:0] UNIT_C = 2'b00;
    localparam logic [1:0] UNIT_F = 2'b01;
    localparam logic [1:0] UNIT_K = 2'b10;

    // Active-low glyphs, bit order gfedcba
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_K     = 7'b0001001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Symbol codes above 9 select the non-digit glyphs
    localparam logic [3:0] SYM_C     = 4'd10;
    localparam logic [3:0] SYM_F     = 4'd11;
    localparam logic [3:0] SYM_K     = 4'd12;
    localparam logic [3:0] SYM_E     = 4'd13;
    localparam logic [3:0] SYM_BLANK = 4'd15;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        SHOW  = 2'd1,
        ALARM = 2'd2
    } disp_state_e;

endpackage

// File: rtl/seg7_encode.sv
// Combinational symbol-code to active-low seven-segment decoder.
`timescale 1ns/1ps
module seg7_encode
    import temp_disp_pkg::*;
(
    input  logic [3:0] sym,
    output logic [6:0] seg
);

    always_comb begin
        case (sym)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            SYM_C:   seg = GLYPH_C;
            SYM_F:   seg = GLYPH_F;
            SYM_K:   seg = GLYPH_K;
            SYM_E:   seg = GLYPH_E;
            default: seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/temp_disp_scan.sv
// Four-digit multiplexed display driver for the temperature converter result,
// with whole-display blinking while the over-temperature flag is held.
`timescale 1ns/1ps
module temp_disp_scan
    import temp_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] temp,
    input  logic [1:0] unit,
    input  logic       over,
    input  logic       upd,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    disp_state_e   state_q, state_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          cap_q, cap_d;
    logic [3:0]    h_temp_q, h_temp_d;
    logic [1:0]    h_unit_q, h_unit_d;
    logic          h_over_q, h_over_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          tick;
    logic          tens;
    logic [3:0]    ones;
    logic [3:0]    sym;
    logic [6:0]    glyph;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        tick       = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = tick ? '0 : scan_cnt_q + 1'b1;
        idx_d      = tick ? idx_q + 2'd1 : idx_q;

        cap_d    = upd;
        h_temp_d = upd ? temp : h_temp_q;
        h_unit_d = upd ? unit : h_unit_q;
        h_over_d = upd ? over : h_over_q;

        // The state follows the hold register one edge after each capture
        state_d = state_q;
        if (cap_q) begin
            state_d = h_over_q ? ALARM : SHOW;
        end

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (state_d != ALARM || state_q != ALARM) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tens = (h_temp_q >= 4'd10);
        ones = tens ? h_temp_q - 4'd10 : h_temp_q;

        case (idx_q)
            2'd0: begin
                case (h_unit_q)
                    UNIT_C:  sym = SYM_C;
                    UNIT_F:  sym = SYM_F;
                    UNIT_K:  sym = SYM_K;
                    default: sym = SYM_E;
                endcase
            end
            2'd1:    sym = ones;
            2'd2:    sym = tens ? 4'd1 : SYM_BLANK;
            default: sym = SYM_BLANK;
        endcase
    end

    seg7_encode u_seg7_encode (
        .sym (sym),
        .seg (glyph)
    );

    always_comb begin
        an_d  = 4'b1111;
        seg_d = GLYPH_BLANK;
        dp_d  = 1'b1;
        if (state_q != BLANK) begin
            seg_d = glyph;
            dp_d  = !(state_q == ALARM && idx_q == 2'd0);
            if (!(state_q == ALARM && !phase_q)) begin
                an_d = ~(4'b0001 << idx_q);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= BLANK;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            cap_q       <= 1'b0;
            h_temp_q    <= '0;
            h_unit_q    <= '0;
            h_over_q    <= 1'b0;
            seg_q       <= GLYPH_BLANK;
            dp_q        <= 1'b1;
            an_q        <= 4'b1111;
        end else begin
            state_q     <= state_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            cap_q       <= cap_d;
            h_temp_q    <= h_temp_d;
            h_unit_q    <= h_unit_d;
            h_over_q    <= h_over_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_temp_disp_scan.sv
// Randomized scoreboard bench for temp_disp_scan against a cycle-count based
// reference model of the scan, blink and capture rules.
`timescale 1ns/1ps
module tb_temp_disp_scan;

    localparam int SD = 4;
    localparam int BD = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] temp = '0;
    logic [1:0] unit = '0;
    logic       over = 1'b0;
    logic       upd = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // Reference model: state 0 = blank, 1 = show, 2 = alarm
    int         m_n, m_state, m_alarm;
    bit         m_cap;
    logic [3:0] m_temp;
    logic [1:0] m_unit;
    bit         m_over;

    temp_disp_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk  (clk),
        .clr  (clr),
        .temp (temp),
        .unit (unit),
        .over (over),
        .upd  (upd),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] digit_glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [6:0] expect_glyph(input int idx);
        if (idx == 0) begin
            case (m_unit)
                2'd0: return 7'b1000110;
                2'd1: return 7'b0001110;
                2'd2: return 7'b0001001;
                default: return 7'b0000110;
            endcase
        end
        if (idx == 1) return digit_glyph(int'(m_temp) % 10);
        if (idx == 2 && m_temp >= 10) return digit_glyph(int'(m_temp) / 10);
        return 7'b1111111;
    endfunction

    task automatic model_reset();
        m_n = 0; m_state = 0; m_alarm = 0; m_cap = 0;
        m_temp = '0; m_unit = '0; m_over = 0;
    endtask

    // Predict the registered pins after the coming edge, then advance the model.
    task automatic model_edge(input bit u, input logic [3:0] t, input logic [1:0] un, input bit ov);
        exp_t e;
        int idx;
        bit lit;
        int ns;
        idx = (m_n / SD) % 4;
        lit = 1;
        if (m_state == 2) lit = (((m_n / SD - m_alarm / SD) / BD) % 2) == 0;
        e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
        if (m_state != 0) begin
            e.seg = expect_glyph(idx);
            e.dp  = !(m_state == 2 && idx == 0);
            if (lit) e.an = ~(4'b0001 << idx);
        end
        exp_q.push_back(e);
        m_n++;
        if (m_cap) begin
            ns = m_over ? 2 : 1;
            if (ns == 2 && m_state != 2) m_alarm = m_n;
            m_state = ns;
        end
        m_cap = u;
        if (u) begin
            m_temp = t; m_unit = un; m_over = ov;
        end
    endtask

    // Called at a negedge: drive inputs, record the expectation, run one clock.
    task automatic step(input bit u, input logic [3:0] t, input logic [1:0] un, input bit ov);
        upd = u; temp = t; unit = un; over = ov;
        model_edge(u, t, un, ov);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_an"},  {12'd0, an},  16'h000F);
        check({tag, "_seg"}, {9'd0, seg},  16'h007F);
        check({tag, "_dp"},  {15'd0, dp},  16'h0001);
    endtask

    // Monitor: compare the oldest expectation a little after every rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an",  {12'd0, an},  {12'd0, e.an});
                check("seg", {9'd0, seg},  {9'd0, e.seg});
                check("dp",  {15'd0, dp},  {15'd0, e.dp});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int run;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_pins("reset");
        clr = 1'b1;

        idle(3 * SD + 2);
        step(1'b1, 4'd13, 2'b00, 1'b0);
        idle(5 * SD);
        step(1'b1, 4'd5, 2'b10, 1'b0);
        idle(5 * SD);
        step(1'b1, 4'd8, 2'b11, 1'b0);
        idle(5 * SD);
        step(1'b1, 4'd10, 2'b01, 1'b1);
        idle(10 * SD * BD);
        step(1'b1, 4'd9, 2'b00, 1'b0);
        idle(6 * SD);

        run = 0;
        for (int i = 0; i < 400; i++) begin
            if (run == 0 && $urandom_range(0, 19) == 0) run = $urandom_range(2, 5);
            if (run > 0) begin
                run--;
                step(1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
            end else begin
                step(($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 2) == 0));
            end
        end

        step(1'b1, 4'd15, 2'b01, 1'b0);
        idle(SD + 3);
        #1;
        clr = 1'b0;
        #1;
        check_reset_pins("midreset");
        upd = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_pins("heldreset");
        clr = 1'b1;
        model_reset();
        idle(3 * SD + 1);
        step(1'b1, 4'd7, 2'b10, 1'b0);
        idle(4 * SD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
